op_issue_queue: RTL and testbench
=================================

# op_issue_queue

Buffers ALU operations (5-bit opcode plus two 32-bit operands) between the instruction front end and the opcode-match/ALU stage. It accepts operations on a valid/ready handshake, filters out illegal opcodes, and presents the oldest legal operation on its output. The output opcode drives the `my_op` input of the opcode-comparison stage directly downstream. The block decouples front-end stalls from ALU stalls through a small FIFO.

## Interface
Parameters:
- DEPTH, 4: number of buffered operations; a power of two, minimum 2.
- OP_W, 5: opcode width.
- DATA_W, 32: operand width.
- OP_MAX, 5'd20: opcodes greater than or equal to this value are illegal.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  upstream holds an operation.
- in_ready  output  1  queue can accept an operation.
- in_op  input  OP_W  opcode.
- in_a, in_b  input  DATA_W  operands.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head.
- out_op  output  OP_W  head opcode, feeds the downstream `my_op`.
- out_a, out_b  output  DATA_W  head operands.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- err_cnt  output  8  number of illegal opcodes dropped; saturating.

## Operation
- Push: occurs when in_valid && in_ready.
  - Legal op (in_op < OP_MAX): the entry is written at the write pointer; wr_ptr increments, wrapping modulo DEPTH.
  - Illegal op: the handshake still completes and the data is discarded. err_cnt increments and saturates at 8'hFF.
- Pop: occurs when out_valid && out_ready. rd_ptr increments, wrapping modulo DEPTH.
- count update: +1 on a legal push only, −1 on a pop only, unchanged when both happen in the same cycle.
- in_ready = (count != DEPTH).
  - Derived only from registered state; there is no combinational path from out_ready.
  - When the queue is full, a simultaneous pop does not admit a push.
- out_valid = (count != 0).
  - out_op, out_a and out_b read from storage at rd_ptr.
  - They hold stable while out_valid && !out_ready.
- flush: at the next edge, count, wr_ptr and rd_ptr all return to 0.
  - Flush has priority over any push or pop in the same cycle. Those transfers are lost, but an illegal-op push still counts in err_cnt.
  - err_cnt is not cleared by flush.
- Empty: out_valid is 0; out_* show stale storage and must be ignored.
- Full: in_ready is 0; upstream must hold its data.

## Timing
- Reset (rst_n low, asynchronous):
  - count, wr_ptr, rd_ptr and err_cnt go to 0; storage goes to 0.
  - out_valid is 0, in_ready is 1, and out_op/out_a/out_b are 0.
- Reset may assert mid-operation. Buffered entries are lost; nothing is required of a transfer in the reset cycle.
- Latency: a legal push at edge N produces out_valid=1 with that entry after edge N when the queue was empty. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle in steady state, provided 0 < count < DEPTH.
- Outputs are glitch-free registered or decoded state; the only combinational logic is the read mux on rd_ptr.

## Structure
- Shared package alu_pkg:
  - OP_W, DATA_W and OP_MAX.
  - typedef op_t (logic [OP_W-1:0]).
  - typedef alu_req_t ({op, a, b}).
  - The same constants are used by the opcode-comparison stage.
- Sub-module op_fifo_mem: DEPTH × alu_req_t register array with one write port, one async read port, and reset to zero.
- Pointer and count control and the illegal-op filter live in the top module.

## Test plan
- Reset, then push op=5'd3, a=32'h1, b=32'h2 with out_ready=0 → after one edge: out_valid=1, out_op=3, out_a=1, out_b=2, count=1.
- Push ops 1, 2, 3, 4 back-to-back with out_ready=0 → count=4 and in_ready=0. A fifth push is stalled. Then pop four entries → outputs appear in order 1, 2, 3, 4.
- Push in_op=5'd25 → handshake completes, count unchanged, err_cnt=1. Then 300 illegal pushes → err_cnt saturates at 255.
- Queue full with out_ready=1 and in_valid=1 on the same cycle → one pop and no push; the next cycle accepts the push; FIFO order is preserved across pointer wrap.
- Three entries stored, then flush=1 together with a push → next cycle count=0, out_valid=0, in_ready=1; the pushed entry is absent.
- Assert rst_n=0 asynchronously mid-stream, between edges → out_valid drops immediately; count=0 and err_cnt=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU request constants and types shared with the opcode-comparison stage
package alu_pkg;

  localparam int OP_W   = 5;
  localparam int DATA_W = 32;
  localparam logic [OP_W-1:0] OP_MAX = 5'd20;

  typedef logic [OP_W-1:0] op_t;

  typedef struct packed {
    op_t               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/op_fifo_mem.sv
// rtl/op_fifo_mem.sv - DEPTH x alu_req_t register array, one write port, async read port
module op_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  alu_req_t         wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output alu_req_t         rd_data
);

  alu_req_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/op_issue_queue.sv
// rtl/op_issue_queue.sv - ALU operation FIFO with illegal-opcode filter and saturating drop counter
module op_issue_queue #(
  parameter int DEPTH = 4,
  parameter int OP_W = alu_pkg::OP_W,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter logic [OP_W-1:0] OP_MAX = alu_pkg::OP_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_op,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_W-1:0]        out_op,
  output logic [DATA_W-1:0]      out_a,
  output logic [DATA_W-1:0]      out_b,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             legal;
  logic             push_ok;
  logic             pop;

  alu_pkg::alu_req_t wr_req;
  alu_pkg::alu_req_t rd_req;

  // Ready/valid decode only from count, so no out_ready -> in_ready path exists.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);

  assign push    = in_valid && in_ready;
  assign legal   = (in_op < OP_MAX);
  assign push_ok = push && legal;
  assign pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Dropped illegal ops are counted even in a flush cycle; flush never clears this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (push && !legal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign wr_req.op = in_op;
  assign wr_req.a  = in_a;
  assign wr_req.b  = in_b;

  op_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (push_ok && !flush),
    .wr_addr (wr_ptr),
    .wr_data (wr_req),
    .rd_addr (rd_ptr),
    .rd_data (rd_req)
  );

  assign out_op = rd_req.op;
  assign out_a  = rd_req.a;
  assign out_b  = rd_req.b;

endmodule

// File: tb/tb_op_issue_queue.sv
// tb/tb_op_issue_queue.sv - scoreboard bench for op_issue_queue
module tb_op_issue_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_op;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  count;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  req_t sb[$];
  int   mcount = 0;
  int   merr = 0;

  op_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_a     (out_a),
    .out_b     (out_b),
    .count     (count),
    .err_cnt   (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model decides acceptance, head order and counters.
  task automatic cycle(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy, input logic fl);
    req_t head;
    logic acc;
    logic lg;
    logic pp;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    flush     = fl;
    check("in_ready", in_ready, (mcount != DEPTH));
    check("out_valid", out_valid, (mcount != 0));
    pp = rdy && (mcount != 0);
    if (pp) begin
      head = sb[0];
      check("out_op", out_op, head.op);
      check("out_a", out_a, head.a);
      check("out_b", out_b, head.b);
    end
    acc = v && (mcount != DEPTH);
    lg  = (op < 5'd20);
    if (acc && !lg && merr != 255) merr++;
    if (fl) begin
      mcount = 0;
      sb.delete();
    end else begin
      if (pp) begin
        void'(sb.pop_front());
        mcount--;
      end
      if (acc && lg) begin
        sb.push_back('{op: op, a: a, b: b});
        mcount++;
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    check("count", count, mcount);
    check("err_cnt", err_cnt, merr);
  endtask

  initial begin
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_count", count, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_out_op", out_op, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, visible one edge later.
    cycle(1'b1, 5'd3, 32'h1, 32'h2, 1'b0, 1'b0);
    check("first_valid", out_valid, 1'b1);
    check("first_op", out_op, 5'd3);
    check("first_a", out_a, 32'h1);
    check("first_b", out_b, 32'h2);
    cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, stalled fifth push, drain in order.
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 5'(i), 32'(i * 16), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    check("full_in_ready", in_ready, 1'b0);
    cycle(1'b1, 5'd5, 32'h55, 32'h66, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Illegal ops, then saturation.
    cycle(1'b1, 5'd25, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
    check("err_one", err_cnt, 8'd1);
    cycle(1'b1, 5'd20, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 5'(20 + (i % 12)), 32'(i), 32'(~i), 1'b0, 1'b0);
    check("err_sat", err_cnt, 8'hFF);

    // Full with simultaneous pop admits no push; order holds across wrap.
    for (int i = 6; i <= 9; i++)
      cycle(1'b1, 5'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 5'd10, 32'h10A, 32'h20A, 1'b1, 1'b0);
    check("full_pop_count", count, 3'd3);
    cycle(1'b1, 5'd10, 32'h10A, 32'h20A, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush together with a push.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'(11 + i), 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 5'd15, 32'h315, 32'h415, 1'b0, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    check("flush_count", count, 0);
    cycle(1'b1, 5'd16, 32'h316, 32'h416, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    cycle(1'b1, 5'd17, 32'h317, 32'h417, 1'b0, 1'b0);
    cycle(1'b1, 5'd18, 32'h318, 32'h418, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_count", count, 0);
    check("arst_err", err_cnt, 0);
    check("arst_ready", in_ready, 1'b1);
    mcount = 0;
    merr = 0;
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 5'd19, 32'h319, 32'h419, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
